// File: rtl/lif_neuron_ctrl.sv
// lif_neuron_ctrl: leaky integrate-and-fire neuron sequencer driving an external index counter
module lif_neuron_ctrl #(
    parameter int                    IDX_W      = 3,
    parameter int                    W_W        = 8,
    parameter int                    V_W        = 12,
    parameter logic signed [V_W-1:0] THRESH     = 100,
    parameter logic signed [V_W-1:0] V_RESET    = 0,
    parameter int                    LEAK_SHIFT = 3,
    parameter int                    REFRAC     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2**IDX_W-1:0]     in_spikes,
    input  logic signed [W_W-1:0]   weight_in,
    input  logic [IDX_W-1:0]        cnt_val,
    input  logic                    cnt_co,
    output logic                    cnt_init,
    output logic                    cnt_en,
    output logic                    busy,
    output logic                    done,
    output logic                    spike,
    output logic signed [V_W-1:0]   vmem
);
    typedef enum logic [2:0] {IDLE, LEAK, ACCUM, FIRE, REFR} state_t;
    state_t                  state_q;
    logic [2**IDX_W-1:0]     spikes_q;
    logic [3:0]              refrac_q;
    logic signed [V_W-1:0]   vmem_q, vmem_leak_d, vmem_acc_d;
    logic signed [V_W:0]     sum;
    logic                    done_q, spike_q;
    // leak and saturating weight accumulation candidates for vmem
    always_comb begin
        vmem_leak_d = vmem_q - (vmem_q >>> LEAK_SHIFT);
        sum         = {vmem_q[V_W-1], vmem_q} + {{(V_W+1-W_W){weight_in[W_W-1]}}, weight_in};
        vmem_acc_d  = (sum[V_W] != sum[V_W-1]) ? (sum[V_W] ? {1'b1, {(V_W-1){1'b0}}} : {1'b0, {(V_W-1){1'b1}}}) : sum[V_W-1:0];
    end
    assign cnt_init = (state_q == IDLE) && start && (refrac_q == 4'd0);
    assign cnt_en   = (state_q == ACCUM);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign spike    = spike_q;
    assign vmem     = vmem_q;
    // time-step sequencer: leak, walk all synapses, fire or sit out a refractory step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            spikes_q <= '0;
            refrac_q <= 4'd0;
            vmem_q   <= '0;
            done_q   <= 1'b0;
            spike_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            spike_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    if (refrac_q != 4'd0) state_q <= REFR;
                    else begin
                        spikes_q <= in_spikes;
                        state_q  <= LEAK;
                    end
                end
                LEAK: begin
                    vmem_q  <= vmem_leak_d;
                    state_q <= ACCUM;
                end
                ACCUM: begin
                    if (spikes_q[cnt_val]) vmem_q <= vmem_acc_d;
                    if (cnt_co) state_q <= FIRE;
                end
                FIRE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (vmem_q >= THRESH) begin
                        vmem_q   <= V_RESET;
                        refrac_q <= 4'(REFRAC);
                        spike_q  <= 1'b1;
                    end
                end
                REFR: begin
                    refrac_q <= refrac_q - 4'd1;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lif_neuron_ctrl.sv
// tb_lif_neuron_ctrl: directed checks of the LIF neuron with a modelled index counter
module tb_lif_neuron_ctrl;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        in_spikes = 8'h00;
    logic signed [7:0] w = 8'sd0;
    logic [2:0]        cnt;
    logic              cnt_co, cnt_init, cnt_en, busy, done, spike;
    logic signed [11:0] vmem;
    int errors = 0;
    int checks = 0;
    int overlap = 0;
    int lat, v_leak, v_acc, nd, fd;

    lif_neuron_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .in_spikes(in_spikes), .weight_in(w),
        .cnt_val(cnt), .cnt_co(cnt_co), .cnt_init(cnt_init), .cnt_en(cnt_en),
        .busy(busy), .done(done), .spike(spike), .vmem(vmem)
    );

    always #5 clk = ~clk;

    // external 3-bit index counter sharing rst
    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 3'd0;
        else if (cnt_init) cnt <= 3'd0;
        else if (cnt_en) cnt <= cnt + 3'd1;
    end
    assign cnt_co = &cnt;

    // init and enable must never be asserted together
    always @(negedge clk) if (cnt_init && cnt_en) overlap++;

    task automatic run_step(input logic [7:0] sp, output int l, output int vl, output int va);
        l = 0; vl = 0; va = 0;
        @(negedge clk); in_spikes = sp; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 2; i <= 20 && l == 0; i++) begin
            @(posedge clk); #1;
            if (i == 2) vl = int'(vmem);
            if (i == 10) va = int'(vmem);
            if (done) l = i;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        #1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (vmem !== 12'sd0) begin errors++; $display("FAIL reset_vmem: got %0d expected 0", vmem); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL reset_spike: got %b expected 0", spike); end
        @(negedge clk); rst = 1'b0;
        w = 8'sd20;
        @(negedge clk); in_spikes = 8'hFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (int'(vmem) !== 40) begin errors++; $display("FAIL pre_rst_vmem: got %0d expected 40", vmem); end
        rst = 1'b1;
        #1;
        checks++; if (vmem !== 12'sd0) begin errors++; $display("FAIL midrst_vmem: got %0d expected 0", vmem); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL midrst_spike: got %b expected 0", spike); end
        @(negedge clk); rst = 1'b0;
        nd = 0;
        repeat (15) begin @(posedge clk); #1; if (done) nd++; end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", nd); end
    endtask

    task automatic test_fire();
        w = 8'sd20;
        run_step(8'hFF, lat, v_leak, v_acc);
        checks++; if (lat !== 11) begin errors++; $display("FAIL fire_latency: got %0d expected 11", lat); end
        checks++; if (v_acc !== 160) begin errors++; $display("FAIL fire_accum: got %0d expected 160", v_acc); end
        checks++; if (spike !== 1'b1) begin errors++; $display("FAIL fire_spike: got %b expected 1", spike); end
        checks++; if (vmem !== 12'sd0) begin errors++; $display("FAIL fire_vreset: got %0d expected 0", vmem); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fire_done_clear: got %b expected 0", done); end
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL fire_spike_clear: got %b expected 0", spike); end
    endtask

    task automatic test_refractory();
        w = 8'sd20;
        for (int k = 0; k < 2; k++) begin
            run_step(8'hFF, lat, v_leak, v_acc);
            checks++; if (lat !== 2) begin errors++; $display("FAIL refr%0d_latency: got %0d expected 2", k, lat); end
            checks++; if (spike !== 1'b0) begin errors++; $display("FAIL refr%0d_spike: got %b expected 0", k, spike); end
            checks++; if (vmem !== 12'sd0) begin errors++; $display("FAIL refr%0d_vmem: got %0d expected 0", k, vmem); end
        end
        run_step(8'h00, lat, v_leak, v_acc);
        checks++; if (lat !== 11) begin errors++; $display("FAIL refr_end_latency: got %0d expected 11", lat); end
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL refr_end_spike: got %b expected 0", spike); end
    endtask

    task automatic test_leak();
        w = 8'sd40;
        run_step(8'h01, lat, v_leak, v_acc);
        checks++; if (lat !== 11) begin errors++; $display("FAIL leak1_latency: got %0d expected 11", lat); end
        checks++; if (int'(vmem) !== 40) begin errors++; $display("FAIL leak1_vmem: got %0d expected 40", vmem); end
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL leak1_spike: got %b expected 0", spike); end
        run_step(8'h00, lat, v_leak, v_acc);
        checks++; if (v_leak !== 35) begin errors++; $display("FAIL leak2_after_leak: got %0d expected 35", v_leak); end
        checks++; if (int'(vmem) !== 35) begin errors++; $display("FAIL leak2_vmem: got %0d expected 35", vmem); end
        run_step(8'h00, lat, v_leak, v_acc);
        checks++; if (int'(vmem) !== 31) begin errors++; $display("FAIL leak3_vmem: got %0d expected 31", vmem); end
    endtask

    task automatic test_saturation();
        do_reset();
        w = -8'sd128;
        run_step(8'hFF, lat, v_leak, v_acc);
        checks++; if (int'(vmem) !== -1024) begin errors++; $display("FAIL sat1_vmem: got %0d expected -1024", vmem); end
        run_step(8'hFF, lat, v_leak, v_acc);
        checks++; if (v_leak !== -896) begin errors++; $display("FAIL sat2_after_leak: got %0d expected -896", v_leak); end
        checks++; if (int'(vmem) !== -1920) begin errors++; $display("FAIL sat2_vmem: got %0d expected -1920", vmem); end
        run_step(8'hFF, lat, v_leak, v_acc);
        checks++; if (v_leak !== -1680) begin errors++; $display("FAIL sat3_after_leak: got %0d expected -1680", v_leak); end
        checks++; if (int'(vmem) !== -2048) begin errors++; $display("FAIL sat3_clamp: got %0d expected -2048", vmem); end
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL sat3_spike: got %b expected 0", spike); end
    endtask

    task automatic test_back_to_back();
        w = 8'sd0;
        @(negedge clk); in_spikes = 8'h00; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        nd = 0; fd = 0;
        for (int i = 2; i <= 11; i++) begin
            @(posedge clk); #1;
            if (done) begin nd++; if (fd == 0) fd = i; end
            if (i == 4) start = 1'b1;
            if (i == 5) start = 1'b0;
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL hs_done_count: got %0d expected 1", nd); end
        checks++; if (fd !== 11) begin errors++; $display("FAIL hs_done_cycle: got %0d expected 11", fd); end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_accept_busy: got %b expected 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL hs_accept_done: got %b expected 0", done); end
        lat = 0;
        for (int i = 2; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (done) lat = i;
        end
        checks++; if (lat !== 11) begin errors++; $display("FAIL hs_second_latency: got %0d expected 11", lat); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL hs_init_en_overlap: got %0d expected 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_fire();
        test_refractory();
        test_leak();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
